ram_write_sequencer: RTL and testbench
======================================

Name: ram_write_sequencer

Overview:
- Controller in front of the 16x8 program RAM (two 4-bit F189-style SRAMs, level-sensitive active-low write enable).
- Owns the RAM address, data, write-enable and bus-enable pins.
- Shares the RAM between the CPU (run mode) and a byte-stream program loader (program mode).
- Generates glitch-free write pulses with address/data setup and hold guaranteed around every pulse.

Parameters:
SETUP_CYCLES, 1, cycles address/data are stable before write_enable_n falls (>=1)
PULSE_CYCLES, 2, cycles write_enable_n is held low (>=1)
HOLD_CYCLES, 1, cycles address/data stay stable after write_enable_n rises (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
prog_mode  in  1  1 = loader owns RAM, 0 = CPU owns RAM
cpu_address  in  4  CPU address (MAR)
cpu_data  in  8  CPU write data (bus)
cpu_wr_req  in  1  CPU write request, held until ack
cpu_wr_ack  out  1  one-cycle pulse, CPU write complete
cpu_rd_en  in  1  CPU RAM-out control, active high
load_start  in  1  one-cycle pulse, begin load (honoured only in IDLE with prog_mode=1)
load_base  in  4  first load address
load_len_m1  in  4  byte count minus 1 (0..15 -> 1..16 bytes)
in_data  in  8  loader byte
in_valid  in  1  loader byte valid
in_ready  out  1  sequencer accepts byte
mem_address  out  4  to RAM address
mem_data  out  8  to RAM data
mem_write_enable_n  out  1  to RAM write enable, active low, registered
mem_bus_enable_n  out  1  to RAM bus enable, active low
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse, load completed all bytes
aborted  out  1  one-cycle pulse, load ended early by prog_mode falling

Behaviour:
- Interface: one clock, clk; reset_n asynchronous, active-low.
- Reset values:
  - Registered outputs: mem_write_enable_n=1, in_ready=0, cpu_wr_ack=0, done=0, aborted=0.
  - Internal registers: latched address=0, latched data=0.
  - FSM=IDLE, so busy=0; mem_bus_enable_n=1 while reset_n=0.
- Reset asserted mid-pulse forces mem_write_enable_n=1 immediately (async).
- States: IDLE, WAIT_DATA, SETUP, PULSE, HOLD, FINISH.
- IDLE, RAM outputs:
  - prog_mode=0: mem_address=cpu_address and mem_data=cpu_data (combinational); mem_bus_enable_n=~cpu_rd_en.
  - prog_mode=1: mem_address/mem_data driven from the latched registers; mem_bus_enable_n=1.
- IDLE, transitions:
  - prog_mode=0, cpu_wr_req=1, cpu_wr_ack=0 -> latch cpu_address/cpu_data, go to SETUP (source=CPU).
  - prog_mode=1, load_start=1 -> latch load_base and remaining=load_len_m1, go to WAIT_DATA (source=LOADER).
  - cpu_wr_req is ignored while prog_mode=1, and load_start is ignored while prog_mode=0.
- Outside IDLE: mem_address/mem_data always come from the latched registers; mem_bus_enable_n=1 (no reads during writes).
- WAIT_DATA:
  - in_ready=1 (registered, asserted on entry).
  - On in_valid & in_ready: latch in_data, drop in_ready, go to SETUP.
  - If prog_mode=0 while waiting: go to FINISH with abort.
- SETUP: SETUP_CYCLES cycles, then PULSE.
- PULSE: mem_write_enable_n=0 for exactly PULSE_CYCLES cycles, then HOLD. Fall and rise are registered edges.
- HOLD: HOLD_CYCLES cycles, then:
  - source=CPU -> FINISH.
  - source=LOADER, remaining=0 -> FINISH with done.
  - source=LOADER, prog_mode=0 -> FINISH with abort.
  - Otherwise: address += 1 (4-bit wrap, 15 -> 0), remaining -= 1, go to WAIT_DATA.
- A write pulse in progress is never truncated by prog_mode changes; only reset truncates it.
- FINISH: one cycle; exactly one of cpu_wr_ack, done or aborted is high; then IDLE.
  - In the IDLE cycle after FINISH, cpu_wr_req is not re-sampled, so a requester sees ack and drops req.
- CPU write latency:
  - req sampled at edge E.
  - write_enable_n low from edge E+SETUP_CYCLES for PULSE_CYCLES cycles.
  - ack high from edge E+SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES for one cycle.
  - Defaults: 4 cycles.
- load_start while busy: ignored.
- in_valid outside WAIT_DATA: ignored (byte not consumed).

Decomposition:
- Shared package: state encoding enum; SRC_CPU/SRC_LOADER constants; RAM_ADDR_W=4, RAM_DATA_W=8.
- One sub-module, write_pulse_timer: counts SETUP/PULSE/HOLD phases and emits phase_done.
- FSM and muxing stay in ram_write_sequencer.

Test Plan:
- Reset mid-PULSE of a CPU write -> mem_write_enable_n=1 same cycle reset_n falls; after release busy=0, all pulses 0.
- prog_mode=0, cpu_address=4'h7, cpu_data=8'hA5, cpu_wr_req held:
  - write_enable_n low exactly 2 cycles; address/data stable 1 cycle before and after.
  - ack 4 cycles after req sampled; RAM[7]=A5.
  - cpu_rd_en=1 then gives mem_bus_enable_n=0.
- prog_mode=1, load_start with load_base=4'hE, load_len_m1=3, bytes 11,22,33,44 with in_valid gaps:
  - RAM[E]=11, RAM[F]=22, RAM[0]=33, RAM[1]=44 (wrap).
  - done pulses once; in_ready low during each write.
- Load in progress, prog_mode dropped during PULSE of byte 2:
  - pulse completes full 2 cycles; aborted pulses; done stays 0.
  - Next address not written.
- prog_mode=1 with cpu_wr_req=1 for 20 cycles -> no write pulse, cpu_wr_ack=0; switch prog_mode=0 -> write proceeds.
- load_len_m1=15 from base 0 with back-to-back in_valid:
  - all 16 addresses written; each byte costs 1 + SETUP + PULSE + HOLD cycles.
  - done after 16th write.

Source files
------------

// File: rtl/ram_write_sequencer_pkg.sv
// Shared types and constants for the program-RAM write sequencer.
// The state encoding is common to the top-level FSM and anything that decodes it.
package ram_write_sequencer_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;
    localparam int TIMER_W    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        SETUP     = 3'd2,
        PULSE     = 3'd3,
        HOLD      = 3'd4,
        FINISH    = 3'd5
    } state_t;

    localparam logic SRC_CPU    = 1'b0;
    localparam logic SRC_LOADER = 1'b1;

endpackage

// File: rtl/ram_write_sequencer_timer.sv
// Phase timer for the SETUP/PULSE/HOLD sequence of a RAM write.
// phase_done is high in the last cycle of the current phase.
module write_pulse_timer
    import ram_write_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               phase_active,
    input  logic [TIMER_W-1:0] phase_len,
    output logic               phase_done
);

    logic [TIMER_W-1:0] cnt_reg;

    assign phase_done = phase_active && (cnt_reg == (phase_len - TIMER_W'(1)));

    // Counter returns to zero at every phase boundary, so each phase starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (!phase_active || phase_done) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/ram_write_sequencer.sv
// Write controller for the 16x8 program RAM, arbitrating between CPU writes
// and a byte-stream loader, with guaranteed setup/hold around each write pulse.
module ram_write_sequencer
    import ram_write_sequencer_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  prog_mode,
    input  logic [RAM_ADDR_W-1:0] cpu_address,
    input  logic [RAM_DATA_W-1:0] cpu_data,
    input  logic                  cpu_wr_req,
    output logic                  cpu_wr_ack,
    input  logic                  cpu_rd_en,
    input  logic                  load_start,
    input  logic [RAM_ADDR_W-1:0] load_base,
    input  logic [RAM_ADDR_W-1:0] load_len_m1,
    input  logic [RAM_DATA_W-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [RAM_ADDR_W-1:0] mem_address,
    output logic [RAM_DATA_W-1:0] mem_data,
    output logic                  mem_write_enable_n,
    output logic                  mem_bus_enable_n,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    state_t                 state_reg;
    logic                   source_reg;
    logic [RAM_ADDR_W-1:0]  addr_reg;
    logic [RAM_DATA_W-1:0]  data_reg;
    logic [RAM_ADDR_W-1:0]  remaining_reg;
    logic                   we_n_reg;
    logic                   in_ready_reg;
    logic                   ack_reg;
    logic                   done_reg;
    logic                   aborted_reg;
    logic                   skip_req_reg;

    logic                   phase_active;
    logic [TIMER_W-1:0]     phase_len;
    logic                   phase_done;
    logic                   cpu_owns_bus;

    always_comb begin
        phase_len    = TIMER_W'(SETUP_CYCLES);
        phase_active = 1'b0;
        case (state_reg)
            SETUP: begin
                phase_len    = TIMER_W'(SETUP_CYCLES);
                phase_active = 1'b1;
            end
            PULSE: begin
                phase_len    = TIMER_W'(PULSE_CYCLES);
                phase_active = 1'b1;
            end
            HOLD: begin
                phase_len    = TIMER_W'(HOLD_CYCLES);
                phase_active = 1'b1;
            end
            default: ;
        endcase
    end

    write_pulse_timer u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .phase_active (phase_active),
        .phase_len    (phase_len),
        .phase_done   (phase_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            source_reg    <= SRC_CPU;
            addr_reg      <= '0;
            data_reg      <= '0;
            remaining_reg <= '0;
            we_n_reg      <= 1'b1;
            in_ready_reg  <= 1'b0;
            ack_reg       <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
            skip_req_reg  <= 1'b0;
        end else begin
            ack_reg      <= 1'b0;
            done_reg     <= 1'b0;
            aborted_reg  <= 1'b0;
            skip_req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // skip_req_reg gives the requester one cycle to drop req after ack.
                    if (!prog_mode && cpu_wr_req && !ack_reg && !skip_req_reg) begin
                        addr_reg   <= cpu_address;
                        data_reg   <= cpu_data;
                        source_reg <= SRC_CPU;
                        state_reg  <= SETUP;
                    end else if (prog_mode && load_start) begin
                        addr_reg      <= load_base;
                        remaining_reg <= load_len_m1;
                        source_reg    <= SRC_LOADER;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    // A byte already handshaken is written before the abort is honoured.
                    if (in_valid && in_ready_reg) begin
                        data_reg     <= in_data;
                        in_ready_reg <= 1'b0;
                        state_reg    <= SETUP;
                    end else if (!prog_mode) begin
                        in_ready_reg <= 1'b0;
                        aborted_reg  <= 1'b1;
                        state_reg    <= FINISH;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        we_n_reg  <= 1'b0;
                        state_reg <= PULSE;
                    end
                end
                PULSE: begin
                    if (phase_done) begin
                        we_n_reg  <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        if (source_reg == SRC_CPU) begin
                            ack_reg   <= 1'b1;
                            state_reg <= FINISH;
                        end else if (remaining_reg == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else if (!prog_mode) begin
                            aborted_reg <= 1'b1;
                            state_reg   <= FINISH;
                        end else begin
                            addr_reg      <= addr_reg + RAM_ADDR_W'(1);
                            remaining_reg <= remaining_reg - RAM_ADDR_W'(1);
                            in_ready_reg  <= 1'b1;
                            state_reg     <= WAIT_DATA;
                        end
                    end
                end
                FINISH: begin
                    skip_req_reg <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: begin
                    we_n_reg     <= 1'b1;
                    in_ready_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign cpu_owns_bus = (state_reg == IDLE) && !prog_mode;

    assign mem_address        = cpu_owns_bus ? cpu_address : addr_reg;
    assign mem_data           = cpu_owns_bus ? cpu_data : data_reg;
    assign mem_bus_enable_n   = ~(reset_n && cpu_owns_bus && cpu_rd_en);
    assign mem_write_enable_n = we_n_reg;
    assign in_ready           = in_ready_reg;
    assign cpu_wr_ack         = ack_reg;
    assign done               = done_reg;
    assign aborted            = aborted_reg;
    assign busy               = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Directed self-checking bench for ram_write_sequencer with a behavioural
// model of the level-sensitive RAM sitting behind it.
module tb_ram_write_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       prog_mode;
    logic [3:0] cpu_address;
    logic [7:0] cpu_data;
    logic       cpu_wr_req;
    logic       cpu_wr_ack;
    logic       cpu_rd_en;
    logic       load_start;
    logic [3:0] load_base;
    logic [3:0] load_len_m1;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_write_enable_n;
    logic       mem_bus_enable_n;
    logic       busy;
    logic       done;
    logic       aborted;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [16];
    int cyc = 0, low_cycles = 0, we_falls = 0;
    int done_cnt = 0, abort_cnt = 0, ack_cnt = 0, done_cyc = 0;
    int ready_viol = 0, sh_viol = 0;
    logic       prev_valid = 1'b0;
    logic       prev_we = 1'b1;
    logic [3:0] prev_addr = '0;
    logic [7:0] prev_data = '0;

    always #5 clk = ~clk;

    ram_write_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .prog_mode          (prog_mode),
        .cpu_address        (cpu_address),
        .cpu_data           (cpu_data),
        .cpu_wr_req         (cpu_wr_req),
        .cpu_wr_ack         (cpu_wr_ack),
        .cpu_rd_en          (cpu_rd_en),
        .load_start         (load_start),
        .load_base          (load_base),
        .load_len_m1        (load_len_m1),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .mem_address        (mem_address),
        .mem_data           (mem_data),
        .mem_write_enable_n (mem_write_enable_n),
        .mem_bus_enable_n   (mem_bus_enable_n),
        .busy               (busy),
        .done               (done),
        .aborted            (aborted)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge mem_write_enable_n) we_falls <= we_falls + 1;

    // RAM model plus protocol monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && !mem_write_enable_n) begin
            ram[mem_address] <= mem_data;
            low_cycles       <= low_cycles + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (aborted) abort_cnt <= abort_cnt + 1;
        if (cpu_wr_ack) ack_cnt <= ack_cnt + 1;
        if (in_ready && !mem_write_enable_n) ready_viol <= ready_viol + 1;
        if (reset_n && prev_valid && (mem_write_enable_n != prev_we) &&
            ((mem_address != prev_addr) || (mem_data != prev_data)))
            sh_viol <= sh_viol + 1;
        prev_valid <= reset_n;
        prev_we    <= mem_write_enable_n;
        prev_addr  <= mem_address;
        prev_data  <= mem_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic start_load(input logic [3:0] base, input logic [3:0] len_m1);
        prog_mode   = 1'b1;
        load_base   = base;
        load_len_m1 = len_m1;
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_busy", busy, 1'b1);
        check("load_ready", in_ready, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        check("byte_ready_seen", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("byte_ready_drop", in_ready, 1'b0);
        $display("load byte %02h accepted at cycle %0d", b, cyc);
    endtask

    initial begin
        int f0, l0, a0, d0, ab0, l1, start_cyc;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        reset_n     = 1'b0;
        prog_mode   = 1'b0;
        cpu_address = '0;
        cpu_data    = '0;
        cpu_wr_req  = 1'b0;
        cpu_rd_en   = 1'b1;
        load_start  = 1'b0;
        load_base   = '0;
        load_len_m1 = '0;
        in_data     = '0;
        in_valid    = 1'b0;

        #12;
        check("rst_we_n", mem_write_enable_n, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_ack", cpu_wr_ack, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bus_en_n", mem_bus_enable_n, 1'b1);
        cpu_rd_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Reset landing in the middle of a write pulse.
        cpu_address = 4'h2;
        cpu_data    = 8'h5A;
        cpu_wr_req  = 1'b1;
        tick();
        tick();
        check("rst_mid_pulse_low", mem_write_enable_n, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_we_async", mem_write_enable_n, 1'b1);
        check("rst_mid_bus_en_n", mem_bus_enable_n, 1'b1);
        cpu_wr_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_rel_busy", busy, 1'b0);
        check("rst_rel_ack", cpu_wr_ack, 1'b0);
        check("rst_rel_done", done, 1'b0);
        check("rst_rel_abort", aborted, 1'b0);
        check("rst_rel_ready", in_ready, 1'b0);
        $display("reset during pulse at cycle %0d", cyc);

        // Plain CPU write: setup 1, pulse 2, hold 1, ack 4 cycles after req sampled.
        f0 = we_falls; l0 = low_cycles;
        cpu_address = 4'h7;
        cpu_data    = 8'hA5;
        cpu_wr_req  = 1'b1;
        tick();
        check("cpu_setup_busy", busy, 1'b1);
        check("cpu_setup_we", mem_write_enable_n, 1'b1);
        check("cpu_setup_addr", mem_address, 4'h7);
        check("cpu_setup_data", mem_data, 8'hA5);
        tick();
        check("cpu_pulse1_we", mem_write_enable_n, 1'b0);
        tick();
        check("cpu_pulse2_we", mem_write_enable_n, 1'b0);
        tick();
        check("cpu_hold_we", mem_write_enable_n, 1'b1);
        check("cpu_hold_addr", mem_address, 4'h7);
        check("cpu_hold_data", mem_data, 8'hA5);
        check("cpu_hold_ack", cpu_wr_ack, 1'b0);
        tick();
        check("cpu_ack", cpu_wr_ack, 1'b1);
        cpu_wr_req = 1'b0;
        tick();
        check("cpu_ack_drop", cpu_wr_ack, 1'b0);
        check("cpu_idle", busy, 1'b0);
        check("cpu_ram7", ram[7], 8'hA5);
        check("cpu_low_cycles", low_cycles - l0, 2);
        check("cpu_falls", we_falls - f0, 1);
        cpu_rd_en = 1'b1;
        #1;
        check("cpu_rd_bus_en_n", mem_bus_enable_n, 1'b0);
        cpu_rd_en = 1'b0;
        $display("cpu write addr=7 data=a5 at cycle %0d", cyc);

        // Four-byte load wrapping E,F,0,1 with gaps on in_valid.
        d0 = done_cnt; ab0 = abort_cnt;
        start_load(4'hE, 4'd3);
        send_byte(8'h11, 2);
        send_byte(8'h22, 0);
        send_byte(8'h33, 3);
        send_byte(8'h44, 1);
        wait_idle();
        check("load_done_cnt", done_cnt - d0, 1);
        check("load_abort_cnt", abort_cnt - ab0, 0);
        check("load_ramE", ram[14], 8'h11);
        check("load_ramF", ram[15], 8'h22);
        check("load_ram0", ram[0], 8'h33);
        check("load_ram1", ram[1], 8'h44);

        // prog_mode drops during the pulse of the second byte.
        d0 = done_cnt; ab0 = abort_cnt;
        start_load(4'h4, 4'd3);
        send_byte(8'h61, 0);
        send_byte(8'h62, 1);
        l1 = low_cycles;
        tick();
        check("abort_pulse_start", mem_write_enable_n, 1'b0);
        prog_mode = 1'b0;
        tick();
        check("abort_pulse_full", mem_write_enable_n, 1'b0);
        tick();
        check("abort_pulse_end", mem_write_enable_n, 1'b1);
        tick();
        check("abort_pulse", aborted, 1'b1);
        check("abort_no_done", done, 1'b0);
        tick();
        check("abort_idle", busy, 1'b0);
        check("abort_low_cycles", low_cycles - l1, 2);
        check("abort_ram5", ram[5], 8'h62);
        check("abort_ram6", ram[6], 8'h00);
        check("abort_done_cnt", done_cnt - d0, 0);
        check("abort_cnt", abort_cnt - ab0, 1);
        $display("load aborted at cycle %0d", cyc);

        // CPU request is ignored while the loader owns the RAM.
        prog_mode   = 1'b1;
        cpu_address = 4'h9;
        cpu_data    = 8'hC3;
        cpu_wr_req  = 1'b1;
        f0 = we_falls; a0 = ack_cnt;
        repeat (20) tick();
        check("prog_no_pulse", we_falls - f0, 0);
        check("prog_no_ack", ack_cnt - a0, 0);
        check("prog_no_busy", busy, 1'b0);
        prog_mode = 1'b0;
        for (int i = 0; i < 20 && !cpu_wr_ack; i++) tick();
        check("prog_then_ack", cpu_wr_ack, 1'b1);
        cpu_wr_req = 1'b0;
        tick();
        check("prog_then_ram9", ram[9], 8'hC3);
        $display("cpu write addr=9 data=c3 at cycle %0d", cyc);

        // Full 16-byte load with in_valid held high.
        f0 = we_falls; d0 = done_cnt;
        start_load(4'h0, 4'd15);
        start_cyc = cyc;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 8'(8'h80 + k);
            for (int i = 0; i < 40 && !in_ready; i++) tick();
            tick();
        end
        in_valid = 1'b0;
        wait_idle();
        check("full_done_latency", done_cyc - start_cyc, 80);
        check("full_done_cnt", done_cnt - d0, 1);
        check("full_falls", we_falls - f0, 16);
        for (int k = 0; k < 16; k++) check("full_ram", ram[k], 8'(8'h80 + k));
        $display("full load of 16 bytes done at cycle %0d", done_cyc);

        check("setup_hold_viol", sh_viol, 0);
        check("ready_during_write", ready_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
